alu_word_seq: RTL

Multi-byte arithmetic sequencer that drives one 8-bit ALU slice (`ALUA`) across an N-byte operand, least-significant byte first, one byte per clock. It chains the slice's carry-out into the next byte's carry-in and accumulates word-level cout / ov / zero flags. It sits between the datapath control and the 8-bit ALU, so the team gets 16/32-bit add/sub without widening the adder.

---
 rtl/alu_word_seq_pkg.sv | 17 +
 rtl/alu_word_seq_alua.sv | 39 +++
 rtl/alu_word_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_word_seq_pkg.sv
// Shared types and constants for the multi-byte ALU sequencer and its 8-bit slice.
package alu_word_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_word_seq_alua.sv
// 8-bit ALU slice: add / subtract with carry chaining, plus bitwise AND / OR.
module ALUA
  import alu_word_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] A,
  input  logic [BYTE_W-1:0] B,
  input  logic [1:0]        S,
  input  logic              cin,
  output logic [BYTE_W-1:0] IS,
  output logic              Cout,
  output logic              OV
);

  logic [BYTE_W-1:0] b_eff;
  logic [BYTE_W:0]   sum;

  always_comb begin
    b_eff = (S == OP_SUB) ? ~B : B;
    sum   = {1'b0, A} + {1'b0, b_eff} + {{BYTE_W{1'b0}}, cin};
    IS    = sum[BYTE_W-1:0];
    Cout  = sum[BYTE_W];
    // Overflow: both addends share a sign that the sum does not.
    OV    = (A[BYTE_W-1] == b_eff[BYTE_W-1]) && (sum[BYTE_W-1] != A[BYTE_W-1]);
    case (S)
      OP_AND: begin
        IS   = A & B;
        Cout = 1'b0;
        OV   = 1'b0;
      end
      OP_OR: begin
        IS   = A | B;
        Cout = 1'b0;
        OV   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_word_seq.sv
// Walks one 8-bit ALU slice across an NBYTES-wide operand, LSB first, chaining
// the carry and accumulating word-level cout / ov / zero flags.
module alu_word_seq
  import alu_word_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic                     cin_i,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     cout,
  output logic                     ov,
  output logic                     zero
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t state, state_nx;

  logic [NBYTES-1:0][BYTE_W-1:0] a_r, b_r, res_r, res_merge;
  logic [1:0]        op_r;
  logic              carry_r;
  logic              zacc;
  logic [IDX_W-1:0]  idx;
  logic [BYTE_W-1:0] a_byte, b_byte;
  logic [BYTE_W-1:0] slice_is;
  logic              slice_cout, slice_ov;
  logic              last_byte;
  logic              slice_zero;

  // Byte selection and result merge use a compare loop so idx never indexes
  // past the operand, whatever NBYTES is.
  always_comb begin
    a_byte    = '0;
    b_byte    = '0;
    res_merge = res_r;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_byte       = a_r[i];
        b_byte       = b_r[i];
        res_merge[i] = slice_is;
      end
    end
  end

  ALUA u_slice (
    .A    (a_byte),
    .B    (b_byte),
    .S    (op_r),
    .cin  (carry_r),
    .IS   (slice_is),
    .Cout (slice_cout),
    .OV   (slice_ov)
  );

  assign last_byte  = (idx == LAST_IDX);
  assign slice_zero = (slice_is == '0);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_byte) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      op_r    <= '0;
      carry_r <= 1'b0;
      zacc    <= 1'b0;
      idx     <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ov      <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op;
            carry_r <= cin_i;
            idx     <= '0;
            zacc    <= 1'b1;
          end
        end
        RUN: begin
          res_r   <= res_merge;
          carry_r <= slice_cout;
          zacc    <= zacc & slice_zero;
          // idx parks on the last byte instead of wrapping.
          if (last_byte) begin
            result <= res_merge;
            cout   <= slice_cout;
            ov     <= slice_ov;
            zero   <= zacc & slice_zero;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
